// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioning slice.
// Used by btn_debounce_ch and button_conditioner (optional BTN_AUTOREPEAT_EN feature lives there).
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, counter debounce FSM, press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while the button stays held.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
`endif
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic btn_raw_n,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

   logic          sync1_q, sync2_q;
   logic          synced;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   // Synchronizer flops idle high so a reset looks like a released button.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_raw_n;
         sync2_q <= sync1_q;
      end
   end

   assign synced = ~sync2_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cnt_width(RMAX);

   logic [RW-1:0] rep_q, rep_d;
   logic          repDone_q, repDone_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rep_q     <= '0;
         repDone_q <= 1'b0;
      end else begin
         rep_q     <= rep_d;
         repDone_q <= repDone_d;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         RELEASED: begin
            if (synced) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!synced) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (SINGLE || cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!synced) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (synced) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (SINGLE || cnt_q == CNT_LAST) begin
               state_d   = RELEASED;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase

`ifdef BTN_AUTOREPEAT_EN
      // Repeat counter advances only while firmly held; RELEASE_WAIT simply holds it.
      rep_d     = rep_q;
      repDone_d = repDone_q;
      if (state_q == PRESSED && synced) begin
         if ((!repDone_q && rep_q == RW'(REPEAT_DELAY - 1)) ||
             ( repDone_q && rep_q == RW'(REPEAT_PERIOD - 1))) begin
            press_d   = 1'b1;
            rep_d     = '0;
            repDone_d = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end else if (state_d != PRESSED && state_d != RELEASE_WAIT) begin
         rep_d     = '0;
         repDone_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low buttons and flags the all-held chord used as CPU reset request.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat press pulses on every channel.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
`endif
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [N_BTN-1:0] btn_raw_n,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             chord_all
);

   logic chord_q;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
      ) u_ch (
         .Clk        (Clk),
         .Reset_n    (Reset_n),
         .btn_raw_n  (btn_raw_n[g]),
         .btn_level  (btn_level[g]),
         .btn_press  (btn_press[g]),
         .btn_release(btn_release[g])
      );
   end

   // Chord follows the debounced levels one cycle late so it is glitch-free for the CPU reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         chord_q <= 1'b0;
      end else begin
         chord_q <= &btn_level;
      end
   end

   assign chord_all = chord_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: behavioural model plus literal timing checks.
// Builds with or without BTN_AUTOREPEAT_EN; expectations follow the macro.
module tb_button_conditioner;

   localparam int N  = 2;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic         Clk;
   logic         Reset_n;
   logic [N-1:0] btn_raw_n;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic         chord_all;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: raw history, accepted level, run of disagreeing samples, held-cycle count.
   logic [N-1:0] hist0, hist1;
   logic [N-1:0] mLevel, mPress, mRelease;
   logic         mChord;
   int           mRun [N];
   int           mHeld[N];

   button_conditioner #(
      .N_BTN          (N),
      .DEBOUNCE_CYCLES(D)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
`endif
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .btn_raw_n  (btn_raw_n),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .chord_all  (chord_all)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] raw, input int cycles);
      btn_raw_n = raw;
      repeat (cycles) @(negedge Clk);
   endtask

   function automatic bit expectPress(input int off);
`ifdef BTN_AUTOREPEAT_EN
      return (off == 0) || (off >= RD && ((off - RD) % RP) == 0);
`else
      return (off == 0);
`endif
   endfunction

   // A level flips once D consecutive samples of the synced input disagree with it.
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hist0    <= '1;
         hist1    <= '1;
         mLevel   <= '0;
         mPress   <= '0;
         mRelease <= '0;
         mChord   <= 1'b0;
         for (int ch = 0; ch < N; ch++) begin
            mRun[ch]  <= 0;
            mHeld[ch] <= 0;
         end
      end else begin
         hist0  <= btn_raw_n;
         hist1  <= hist0;
         mChord <= &mLevel;
         for (int ch = 0; ch < N; ch++) begin
            automatic logic want = ~hist1[ch];
            automatic logic lvl  = mLevel[ch];
            automatic logic p    = 1'b0;
            automatic logic r    = 1'b0;
            automatic int   run  = mRun[ch];
            automatic int   held = mHeld[ch];
            if (want != lvl) begin
               run++;
               if (run >= D) begin
                  lvl  = want;
                  p    = want;
                  r    = ~want;
                  run  = 0;
                  held = 0;
               end
            end else begin
               if (lvl && run == 0) begin
                  held++;
`ifdef BTN_AUTOREPEAT_EN
                  if (held == RD || (held > RD && ((held - RD) % RP) == 0)) p = 1'b1;
`endif
               end
               run = 0;
            end
            mLevel[ch]   <= lvl;
            mPress[ch]   <= p;
            mRelease[ch] <= r;
            mRun[ch]     <= run;
            mHeld[ch]    <= held;
         end
      end
   end

   always @(negedge Clk) begin
      checkOutput("level",   btn_level,   mLevel);
      checkOutput("press",   btn_press,   mPress);
      checkOutput("release", btn_release, mRelease);
      checkOutput("chord",   {1'b0, chord_all}, {1'b0, mChord});
   end

   initial begin
      Reset_n   = 1'b0;
      btn_raw_n = 2'b00;
      @(negedge Clk);
      repeat (2) @(negedge Clk);
      checkOutput("rst_level", btn_level, 2'b00);
      checkOutput("rst_press", btn_press, 2'b00);
      checkOutput("rst_chord", {1'b0, chord_all}, 2'b00);

      // Release reset with both buttons held: exactly one press, six cycles later.
      Reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         checkOutput("rst_held_press", btn_press, (k == 6) ? 2'b11 : 2'b00);
      end
      applyStimulus(2'b11, 12);

      // Clean press and release on channel 0.
      applyStimulus(2'b10, 0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         checkOutput("clean_level0", {1'b0, btn_level[0]}, {1'b0, k >= 6});
         checkOutput("clean_press0", {1'b0, btn_press[0]}, {1'b0, k == 6});
      end
      applyStimulus(2'b11, 0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         checkOutput("clean_release0", {1'b0, btn_release[0]}, {1'b0, k == 6});
      end
      applyStimulus(2'b11, 6);

      // Bounce shorter than the debounce window never gets accepted.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'b10, 3);
         applyStimulus(2'b11, 1);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         checkOutput("bounce_press0", {1'b0, btn_press[0]}, 2'b00);
         checkOutput("bounce_level0", {1'b0, btn_level[0]}, 2'b00);
      end

      // Chord: ch1 then ch0 two cycles later, then drop ch1.
      applyStimulus(2'b01, 2);
      applyStimulus(2'b00, 0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (k == 6) begin
            checkOutput("chord_lvl0", {1'b0, btn_level[0]}, 2'b01);
            checkOutput("chord_early", {1'b0, chord_all}, 2'b00);
         end
         if (k == 7) checkOutput("chord_set", {1'b0, chord_all}, 2'b01);
      end
      applyStimulus(2'b10, 0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         if (k == 6) begin
            checkOutput("chord_lvl1_fall", {1'b0, btn_level[1]}, 2'b00);
            checkOutput("chord_hold", {1'b0, chord_all}, 2'b01);
         end
         if (k == 7) checkOutput("chord_clear", {1'b0, chord_all}, 2'b00);
      end
      applyStimulus(2'b11, 10);

      // Async reset while ch0 sits in PRESS_WAIT with ch1 already accepted.
      applyStimulus(2'b01, 8);
      applyStimulus(2'b00, 4);
      #2 Reset_n = 1'b0;
      #1;
      checkOutput("async_rst_level", btn_level, 2'b00);
      checkOutput("async_rst_press", btn_press, 2'b00);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge Clk);
         checkOutput("post_rst_press", btn_press, (k == 6) ? 2'b11 : 2'b00);
      end
      applyStimulus(2'b11, 10);

      // Long hold on ch0: single press, or repeats when auto-repeat is built in.
      applyStimulus(2'b10, 0);
      for (int k = 1; k <= 65; k++) begin
         @(negedge Clk);
         checkOutput("hold_press0", {1'b0, btn_press[0]}, {1'b0, (k >= 6) && expectPress(k - 6)});
      end
      applyStimulus(2'b11, 10);

      // Random segments, with the occasional short async reset pulse.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(N'($urandom_range(0, 3)), $urandom_range(1, 40));
         if ($urandom_range(0, 49) == 0) begin
            #2 Reset_n = 1'b0;
            #2 Reset_n = 1'b1;
            @(negedge Clk);
         end
      end
      applyStimulus(2'b11, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
